ucsbece154b_evict_buffer: RTL and testbench

- Small FIFO write buffer between the L1 data array's eviction path and the victim cache write port.
- Absorbs bursts of evicted lines and drains them one per cycle into the victim cache (we/waddr/wdata).
- Lets the L1 miss path search lines still in flight, so an evicted line is never invisible to either structure.
- Coalesces a re-eviction of the same line into the existing entry instead of allocating a new one.

---
 rtl/ucsbece154b_evict_buffer.sv | 157 +++++++++++++++
 tb/tb_ucsbece154b_evict_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_evict_buffer.sv
// Eviction write buffer: FIFO between L1 evictions and the victim cache write port.
// Optional statistics counters are enabled with `define EVICT_BUF_STATS_EN.
module ucsbece154b_evict_buffer #(
  parameter int ADDR_WIDTH = 56,
  parameter int LINE_WIDTH = 128,
  parameter int DEPTH      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    evict_valid_i,
  output logic                    evict_ready_o,
  input  logic [ADDR_WIDTH-1:0]   evict_addr_i,
  input  logic [LINE_WIDTH-1:0]   evict_data_i,
  input  logic                    drain_hold_i,
  output logic                    vc_we_o,
  output logic [ADDR_WIDTH-1:0]   vc_waddr_o,
  output logic [LINE_WIDTH-1:0]   vc_wdata_o,
  input  logic [ADDR_WIDTH-1:0]   lookup_addr_i,
  output logic                    lookup_hit_o,
  output logic [LINE_WIDTH-1:0]   lookup_data_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o,
  output logic                    full_o
`ifdef EVICT_BUF_STATS_EN
  ,
  output logic [31:0]             stat_enq_o,
  output logic [31:0]             stat_merge_o,
  output logic [31:0]             stat_drain_o,
  output logic [31:0]             stat_full_o
`endif
);

  localparam int PW  = $clog2(DEPTH);
  localparam int OFF = $clog2(LINE_WIDTH / 8);

  logic [PW:0]           r_rd_ptr;
  logic [PW:0]           r_wr_ptr;
  logic [PW:0]           r_count;
  logic [DEPTH-1:0]      r_valid;
  logic [ADDR_WIDTH-1:0] r_tag  [DEPTH];
  logic [LINE_WIDTH-1:0] r_data [DEPTH];

  logic                  w_full;
  logic                  w_empty;
  logic                  w_drain;
  logic                  w_enq;
  logic                  w_merge;
  logic                  w_alloc;
  logic [PW-1:0]         w_head;
  logic [PW-1:0]         w_tail;
  logic [PW-1:0]         w_idx;
  logic                  w_cm_hit;
  logic [PW-1:0]         w_cm_idx;
  logic                  w_lk_hit;
  logic [PW-1:0]         w_lk_idx;
  logic [ADDR_WIDTH-1:0] w_new_tag;

  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_drain   = !w_empty && !drain_hold_i;
  assign w_head    = r_rd_ptr[PW-1:0];
  assign w_tail    = r_wr_ptr[PW-1:0];
  assign w_enq     = evict_valid_i && !w_full;
  assign w_merge   = w_enq && w_cm_hit;
  assign w_alloc   = w_enq && !w_cm_hit;
  assign w_new_tag = {evict_addr_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    w_idx    = '0;
    w_cm_hit = 1'b0;
    w_cm_idx = '0;
    w_lk_hit = 1'b0;
    w_lk_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_head + PW'(k);
      if (r_valid[w_idx] &&
          r_tag[w_idx][ADDR_WIDTH-1:OFF] == evict_addr_i[ADDR_WIDTH-1:OFF] &&
          !(w_drain && w_idx == w_head)) begin
        w_cm_hit = 1'b1;
        w_cm_idx = w_idx;
      end
      if (r_valid[w_idx] &&
          r_tag[w_idx][ADDR_WIDTH-1:OFF] == lookup_addr_i[ADDR_WIDTH-1:OFF]) begin
        w_lk_hit = 1'b1;
        w_lk_idx = w_idx;
      end
    end
  end

  assign evict_ready_o = !w_full;
  assign vc_we_o       = w_drain;
  assign vc_waddr_o    = r_tag[w_head];
  assign vc_wdata_o    = r_data[w_head];
  assign lookup_hit_o  = w_lk_hit;
  assign lookup_data_o = w_lk_hit ? r_data[w_lk_idx] : '0;
  assign count_o       = r_count;
  assign empty_o       = w_empty;
  assign full_o        = w_full;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_drain) begin
        r_valid[w_head] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      if (w_merge) begin
        r_data[w_cm_idx] <= evict_data_i;
      end
      if (w_alloc) begin
        r_valid[w_tail] <= 1'b1;
        r_tag[w_tail]   <= w_new_tag;
        r_data[w_tail]  <= evict_data_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      r_count <= r_count + (PW+1)'(w_alloc) - (PW+1)'(w_drain);
    end
  end

`ifdef EVICT_BUF_STATS_EN
  logic [31:0] r_stat_enq;
  logic [31:0] r_stat_merge;
  logic [31:0] r_stat_drain;
  logic [31:0] r_stat_full;

  // Flush clears the buffer but not the statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_enq   <= '0;
      r_stat_merge <= '0;
      r_stat_drain <= '0;
      r_stat_full  <= '0;
    end else if (!flush_i) begin
      if (w_enq && r_stat_enq != '1)
        r_stat_enq <= r_stat_enq + 1'b1;
      if (w_merge && r_stat_merge != '1)
        r_stat_merge <= r_stat_merge + 1'b1;
      if (w_drain && r_stat_drain != '1)
        r_stat_drain <= r_stat_drain + 1'b1;
      if (evict_valid_i && w_full && r_stat_full != '1)
        r_stat_full <= r_stat_full + 1'b1;
    end
  end

  assign stat_enq_o   = r_stat_enq;
  assign stat_merge_o = r_stat_merge;
  assign stat_drain_o = r_stat_drain;
  assign stat_full_o  = r_stat_full;
`endif

endmodule

// File: tb/tb_ucsbece154b_evict_buffer.sv
// Scoreboard bench for ucsbece154b_evict_buffer: directed vectors,
// expected victim-cache writes queued by stimulus, checked by a monitor.
module tb_ucsbece154b_evict_buffer;

  localparam int AW = 56;
  localparam int LW = 128;
  localparam int D  = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          evict_valid_i;
  logic          evict_ready_o;
  logic [AW-1:0] evict_addr_i;
  logic [LW-1:0] evict_data_i;
  logic          drain_hold_i;
  logic          vc_we_o;
  logic [AW-1:0] vc_waddr_o;
  logic [LW-1:0] vc_wdata_o;
  logic [AW-1:0] lookup_addr_i;
  logic          lookup_hit_o;
  logic [LW-1:0] lookup_data_o;
  logic [2:0]    count_o;
  logic          empty_o;
  logic          full_o;
`ifdef EVICT_BUF_STATS_EN
  logic [31:0]   stat_enq_o;
  logic [31:0]   stat_merge_o;
  logic [31:0]   stat_drain_o;
  logic [31:0]   stat_full_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  wr_t exp_q[$];

  localparam logic [LW-1:0] DA = {4{32'hAAAA_0001}};
  localparam logic [LW-1:0] DB = {4{32'hBBBB_0002}};
  localparam logic [LW-1:0] DC = {4{32'hCCCC_0003}};
  localparam logic [LW-1:0] DD = {4{32'hDDDD_0004}};
  localparam logic [LW-1:0] DE = {4{32'hEEEE_0005}};
  localparam logic [LW-1:0] DF = {4{32'hFFFF_0006}};
  localparam logic [LW-1:0] DX = {4{32'h5555_0007}};

  ucsbece154b_evict_buffer #(
    .ADDR_WIDTH(AW),
    .LINE_WIDTH(LW),
    .DEPTH(D)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .evict_valid_i(evict_valid_i),
    .evict_ready_o(evict_ready_o),
    .evict_addr_i(evict_addr_i),
    .evict_data_i(evict_data_i),
    .drain_hold_i(drain_hold_i),
    .vc_we_o(vc_we_o),
    .vc_waddr_o(vc_waddr_o),
    .vc_wdata_o(vc_wdata_o),
    .lookup_addr_i(lookup_addr_i),
    .lookup_hit_o(lookup_hit_o),
    .lookup_data_o(lookup_data_o),
    .count_o(count_o),
    .empty_o(empty_o),
    .full_o(full_o)
`ifdef EVICT_BUF_STATS_EN
    ,
    .stat_enq_o(stat_enq_o),
    .stat_merge_o(stat_merge_o),
    .stat_drain_o(stat_drain_o),
    .stat_full_o(stat_full_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [LW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic enq(input logic [AW-1:0] a, input logic [LW-1:0] d);
    evict_valid_i = 1'b1;
    evict_addr_i  = a;
    evict_data_i  = d;
    tick();
    evict_valid_i = 1'b0;
  endtask

  // Monitor: every victim-cache write must match the oldest expected one.
  always @(negedge clk) begin
    if (vc_we_o === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL vc_write_unexpected: got addr %0h data %0h, want none",
                 vc_waddr_o, vc_wdata_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (vc_waddr_o !== e.addr || vc_wdata_o !== e.data) begin
          n_err++;
          $display("FAIL vc_write: got %0h/%0h, want %0h/%0h",
                   vc_waddr_o, vc_wdata_o, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    evict_valid_i = 1'b0;
    evict_addr_i  = '0;
    evict_data_i  = '0;
    drain_hold_i  = 1'b0;
    lookup_addr_i = 56'h100;
    repeat (2) tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_we", vc_we_o, 0);
    chk("rst_ready", evict_ready_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_hit", lookup_hit_o, 0);
    tick();

    // Fill to full while held, then one ignored enqueue.
    drain_hold_i = 1'b1;
    enq(56'h100, DA); push(56'h100, DA);
    enq(56'h200, DB); push(56'h200, DB);
    enq(56'h300, DC); push(56'h300, DC);
    enq(56'h400, DD); push(56'h400, DD);
    @(negedge clk);
    chk("fill_count", count_o, 4);
    chk("fill_full", full_o, 1);
    chk("fill_ready", evict_ready_o, 0);
    chk("fill_empty", empty_o, 0);
    tick();
    enq(56'h500, DX);
    @(negedge clk);
    chk("ignored_count", count_o, 4);
    tick();
    drain_hold_i = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("drain_empty", empty_o, 1);
    chk("drain_we", vc_we_o, 0);
    tick();

    // Coalesce of the same line while held.
    drain_hold_i = 1'b1;
    enq(56'h100, DA);
    enq(56'h104, DE); push(56'h100, DE);
    lookup_addr_i = 56'h108;
    @(negedge clk);
    chk("merge_count", count_o, 1);
    chk("merge_hit", lookup_hit_o, 1);
    chk("merge_data", lookup_data_o, DE);
    tick();
    drain_hold_i = 1'b0;
    tick();
    @(negedge clk);
    chk("merge_empty", empty_o, 1);
    tick();

    // Re-eviction of the head while it drains allocates a new entry.
    drain_hold_i = 1'b1;
    enq(56'h100, DA); push(56'h100, DA);
    drain_hold_i  = 1'b0;
    evict_valid_i = 1'b1;
    evict_addr_i  = 56'h100;
    evict_data_i  = DF;
    push(56'h100, DF);
    lookup_addr_i = 56'h100;
    @(negedge clk);
    chk("head_drain_hit", lookup_hit_o, 1);
    chk("head_drain_data", lookup_data_o, DA);
    tick();
    evict_valid_i = 1'b0;
    @(negedge clk);
    chk("head_realloc_count", count_o, 1);
    tick();
    @(negedge clk);
    chk("head_realloc_empty", count_o, 0);
    tick();

    // Streaming: enqueue and drain every cycle across pointer wraps.
    for (int i = 0; i < 20; i++) begin
      evict_valid_i = 1'b1;
      evict_addr_i  = 56'h1000 + 56'(i * 16);
      evict_data_i  = {4{32'(i + 32'h100)}};
      push(evict_addr_i, evict_data_i);
      @(negedge clk);
      if (i > 0) chk($sformatf("stream_count_%0d", i), count_o, 1);
      tick();
    end
    evict_valid_i = 1'b0;
    @(negedge clk);
    chk("stream_tail_count", count_o, 1);
    tick();
    @(negedge clk);
    chk("stream_done_count", count_o, 0);
    tick();

    // Flush drops three held entries.
    drain_hold_i = 1'b1;
    enq(56'h2000, DA);
    enq(56'h2010, DB);
    enq(56'h2020, DC);
    @(negedge clk);
    chk("preflush_count", count_o, 3);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i      = 1'b0;
    drain_hold_i = 1'b0;
    @(negedge clk);
    chk("flush_count", count_o, 0);
    chk("flush_we", vc_we_o, 0);
    chk("flush_empty", empty_o, 1);
    for (int j = 0; j < 3; j++) begin
      lookup_addr_i = 56'h2000 + 56'(j * 16);
      #1;
      chk($sformatf("flush_hit_%0d", j), lookup_hit_o, 0);
    end
    repeat (3) tick();
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
